// File: rtl/truth_table_scanner.sv
// Truth-table scanner: drives all 16 {a,b} vectors into a 2-bit logic stage,
// lets each settle, captures c into a packed table and compares it against
// the golden table. Reports pass/fail and the first mismatching index.
module truth_table_scanner #(
  parameter int unsigned SETTLE   = 2,
  parameter logic [31:0] EXPECTED = 32'h5A5AF5C0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [1:0]  a,
  output logic [1:0]  b,
  input  logic [1:0]  c_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] table_out,
  output logic        pass,
  output logic        fail,
  output logic [3:0]  fail_idx
);

  generate
    if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
      $error("truth_table_scanner: SETTLE must be in 1..15");
    end
  endgenerate

  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CAPTURE, S_DONE} state_t;

  state_t     state, state_nxt;
  logic [3:0] idx;
  logic [3:0] cnt;
  logic [1:0] exp_c;

  // Operands are the index register itself, so {a,b} is always registered
  // and naturally holds 4'hF after the last vector until the next start.
  assign {a, b} = idx;
  assign exp_c  = EXPECTED[{idx, 1'b0} +: 2];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: start is only honoured in IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_SETTLE;
      S_SETTLE:  if (cnt == 4'd0) state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = (idx == 4'hF) ? S_DONE : S_SETTLE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    busy = (state == S_SETTLE) || (state == S_CAPTURE);
    done = (state == S_DONE);
  end

  // Datapath: vector index, settle counter, captured table and verdict
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      cnt       <= '0;
      table_out <= '0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      fail_idx  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            table_out <= '0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            fail_idx  <= '0;
            idx       <= '0;
            cnt       <= CNT_INIT;
          end
        end
        S_SETTLE: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
        end
        S_CAPTURE: begin
          table_out[{idx, 1'b0} +: 2] <= c_in;
          // only the first mismatch is latched
          if (c_in != exp_c && !fail) begin
            fail     <= 1'b1;
            fail_idx <= idx;
          end
          if (idx == 4'hF) begin
            // last entry is still in flight, so splice it in for the compare
            pass <= ({c_in, table_out[29:0]} == EXPECTED);
          end else begin
            idx <= idx + 4'd1;
            cnt <= CNT_INIT;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: two instances (SETTLE=2 and SETTLE=1) share
// clock, reset and start; each sees a logic stage modelled as a lookup table.
module tb_truth_table_scanner;

  localparam logic [31:0] GOLD = 32'h5A5AF5C0;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [1:0][1:0]  a_s, b_s, c_s;
  logic [1:0]       busy_s, done_s, pass_s, fail_s;
  logic [1:0][31:0] tab_s;
  logic [1:0][3:0]  fidx_s;
  logic [1:0]       tbl [16];

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_tab;
  logic        exp_pass, exp_fail;
  logic [3:0]  exp_fidx;

  always #5 clk = ~clk;

  // logic stage: c = f(a,b), f given as a 16-entry table
  assign c_s[0] = tbl[{a_s[0], b_s[0]}];
  assign c_s[1] = tbl[{a_s[1], b_s[1]}];

  truth_table_scanner #(.SETTLE(2), .EXPECTED(GOLD)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a(a_s[0]), .b(b_s[0]), .c_in(c_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .table_out(tab_s[0]),
    .pass(pass_s[0]), .fail(fail_s[0]), .fail_idx(fidx_s[0])
  );

  truth_table_scanner #(.SETTLE(1), .EXPECTED(GOLD)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a(a_s[1]), .b(b_s[1]), .c_in(c_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .table_out(tab_s[1]),
    .pass(pass_s[1]), .fail(fail_s[1]), .fail_idx(fidx_s[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Fill the logic-stage table and derive the expected scan result from it
  task automatic set_table(input int mode);
    logic [1:0] g;
    for (int i = 0; i < 16; i++) begin
      g = 2'((GOLD >> (2 * i)) & 32'd3);
      case (mode)
        0:       tbl[i] = g;
        1:       tbl[i] = g & 2'b10;            // c[0] stuck at 0
        2:       tbl[i] = 2'($urandom_range(0, 3));
        default: tbl[i] = g;
      endcase
    end
    if (mode == 3) tbl[$urandom_range(0, 15)] ^= 2'($urandom_range(1, 3));
    exp_tab  = '0;
    exp_fail = 1'b0;
    exp_fidx = '0;
    for (int i = 0; i < 16; i++) begin
      exp_tab = exp_tab | (32'(tbl[i]) << (2 * i));
      if (!exp_fail && 32'(tbl[i]) != ((GOLD >> (2 * i)) & 32'd3)) begin
        exp_fail = 1'b1;
        exp_fidx = 4'(i);
      end
    end
    exp_pass = (exp_tab == GOLD);
  endtask

  task automatic chk_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s d%0d ab", tag, d), 32'({a_s[d], b_s[d]}), 0);
      chk($sformatf("%s d%0d busy", tag, d), 32'(busy_s[d]), 0);
      chk($sformatf("%s d%0d done", tag, d), 32'(done_s[d]), 0);
      chk($sformatf("%s d%0d pass", tag, d), 32'(pass_s[d]), 0);
      chk($sformatf("%s d%0d fail", tag, d), 32'(fail_s[d]), 0);
      chk($sformatf("%s d%0d table", tag, d), tab_s[d], 0);
      chk($sformatf("%s d%0d fidx", tag, d), 32'(fidx_s[d]), 0);
    end
  endtask

  task automatic chk_result(input string tag, input int d);
    chk({tag, " table"}, tab_s[d], exp_tab);
    chk({tag, " pass"}, 32'(pass_s[d]), 32'(exp_pass));
    chk({tag, " fail"}, 32'(fail_s[d]), 32'(exp_fail));
    chk({tag, " fidx"}, 32'(fidx_s[d]), 32'(exp_fidx));
  endtask

  // k = number of edges after the start-sampling edge (edge 0)
  task automatic check_dut(input int d, input int k, input bit hold);
    int    s, l, kk;
    string t;
    s  = (d == 0) ? 2 : 1;
    l  = 16 * (s + 1);
    kk = hold ? (k % (l + 2)) : k;
    t  = $sformatf("d%0d k%0d", d, k);
    if (kk < l) begin
      chk({t, " ab"}, 32'({a_s[d], b_s[d]}), 32'(kk / (s + 1)));
      chk({t, " busy"}, 32'(busy_s[d]), 1);
      chk({t, " done"}, 32'(done_s[d]), 0);
      if (kk == 0) begin
        chk({t, " clr table"}, tab_s[d], 0);
        chk({t, " clr pass"}, 32'(pass_s[d]), 0);
        chk({t, " clr fail"}, 32'(fail_s[d]), 0);
        chk({t, " clr fidx"}, 32'(fidx_s[d]), 0);
      end
    end else begin
      chk({t, " done"}, 32'(done_s[d]), (kk == l) ? 1 : 0);
      chk({t, " busy"}, 32'(busy_s[d]), 0);
      chk({t, " ab"}, 32'({a_s[d], b_s[d]}), 15);
      chk_result(t, d);
    end
  endtask

  task automatic run_scan(input int mode, input bit rep, input bit hold);
    int ncyc;
    set_table(mode);
    ncyc = hold ? 100 : 50;
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      check_dut(0, k, hold);
      check_dut(1, k, hold);
      start = (hold && k != ncyc - 1) || (rep && (k == 5 || k == 20));
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    set_table(0);
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // golden scan with ignored re-pulses of start
    run_scan(0, 1'b1, 1'b0);
    chk("golden table", tab_s[0], 32'h5A5AF5C0);
    chk("golden pass", 32'(pass_s[0]), 1);

    // c[0] stuck at 0
    run_scan(1, 1'b0, 1'b0);
    chk("stuck table", tab_s[0], 32'h0A0AA080);
    chk("stuck fail", 32'(fail_s[0]), 1);
    chk("stuck fidx", 32'(fidx_s[0]), 3);

    // asynchronous reset mid-cycle clears everything before the next edge
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("async rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // abort a scan at idx 7, then rescan
    set_table(0);
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 22; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("abort ab", 32'({a_s[0], b_s[0]}), 7);
    #2 rst_n = 1'b0;
    #1 chk_zero("abort rst");
    repeat (3) begin
      @(negedge clk);
      chk_zero("abort hold");
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk_zero("abort idle");
    run_scan(0, 1'b0, 1'b0);
    chk("rescan pass", 32'(pass_s[0]), 1);

    // start held high: back-to-back scans with one idle cycle between them
    run_scan(3, 1'b0, 1'b1);

    // randomized tables
    for (int r = 0; r < 20; r++)
      run_scan(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
